// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host frame receiver and scancode prefix resolver feeding the keyboard matrix.
// Optional typematic repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
//
// state    | meaning
// ---------|-----------------------------------------------
// S_IDLE   | waiting for a start bit (data low on fall)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd parity bit
// S_STOP   | checking stop bit and parity, processing byte
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 56000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        parity_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fclk;
  logic [7:0]    filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext;
  logic          rel;
  logic [2:0]    skip;

  logic          frame_ok;
  logic          is_discard;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]    lm_code;
  logic          lm_valid;
  logic          lm_match;
  assign lm_match = lm_valid && (lm_code == {ext, shift});
`endif

  // fclk only follows the synchronised clock after FILTER_LEN consecutive differing cycles
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      fclk     <= 1'b1;
      filt_cnt <= 8'd0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] != fclk) begin
        if (filt_cnt == FILT_LAST) begin
          fclk     <= clk_sync[1];
          filt_cnt <= 8'd0;
          fall     <= fclk;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= 8'd0;
      end
    end
  end

  always_comb begin
    frame_ok   = dat_sync[1] && (^{shift, par_bit});
    is_discard = 1'b0;
    case (shift)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_discard = 1'b1;
      default: is_discard = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      ext        <= 1'b0;
      rel        <= 1'b0;
      skip       <= 3'd0;
      ps2_key    <= 11'h000;
      parity_err <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      lm_code    <= 9'd0;
      lm_valid   <= 1'b0;
`endif
    end else begin
      parity_err <= 1'b0;

      if (fall || state == S_IDLE)
        to_cnt <= '0;
      else if (to_cnt == TO_LAST)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TW'(1);

      if (fall) begin
        case (state)
          S_IDLE: begin
            if (!dat_sync[1]) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shift   <= {dat_sync[1], shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_sync[1];
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (!frame_ok) begin
              parity_err <= 1'b1;
              ext        <= 1'b0;
              rel        <= 1'b0;
            end else if (skip != 3'd0) begin
              skip <= skip - 3'd1;
            end else if (shift == 8'hE0) begin
              ext <= 1'b1;
            end else if (shift == 8'hF0) begin
              rel <= 1'b1;
            end else if (shift == 8'hE1) begin
              skip <= 3'd7;
            end else if (is_discard) begin
              ext <= 1'b0;
              rel <= 1'b0;
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (rel) begin
                ps2_key <= {~ps2_key[10], 1'b0, ext, shift};
                if (lm_match) lm_valid <= 1'b0;
              end else if (!lm_match) begin
                ps2_key  <= {~ps2_key[10], 1'b1, ext, shift};
                lm_code  <= {ext, shift};
                lm_valid <= 1'b1;
              end
`else
              ps2_key <= {~ps2_key[10], ~rel, ext, shift};
`endif
              ext <= 1'b0;
              rel <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE && to_cnt == TO_LAST) begin
        // abandoned frame: drop silently, no error pulse
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised bench for ps2_key_decoder with a byte-level behavioural model of the key event rules.
// Expectations for the repeat-suppression case follow PS2_TYPEMATIC_FILTER_EN when it is defined.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 20;
  localparam int GAP        = 10;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        parity_err;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .parity_err(parity_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] exp_key = 11'h000;
  int          exp_toggles = 0;
  int          exp_perr = 0;
  bit          m_ext = 0;
  bit          m_rel = 0;
  int          m_skip = 0;
  logic [8:0]  m_last = 9'd0;
  bit          m_last_v = 0;

  int   tog_cnt = 0;
  int   perr_cnt = 0;
  logic prev_t;
  bit   chk_en = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    exp_key  = 11'h000;
    m_ext    = 0;
    m_rel    = 0;
    m_skip   = 0;
    m_last_v = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    bit emit;
    if (!ok) begin
      exp_perr++;
      m_ext = 0;
      m_rel = 0;
      return;
    end
    if (m_skip != 0) begin
      m_skip--;
      return;
    end
    case (b)
      8'hE0: m_ext = 1;
      8'hF0: m_rel = 1;
      8'hE1: m_skip = 7;
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin m_ext = 0; m_rel = 0; end
      default: begin
        emit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!m_rel) begin
          if (m_last_v && m_last == {m_ext, b}) emit = 0;
          else begin m_last = {m_ext, b}; m_last_v = 1; end
        end else if (m_last_v && m_last == {m_ext, b}) begin
          m_last_v = 0;
        end
`endif
        if (emit) begin
          exp_key = {~exp_key[10], ~m_rel, m_ext, b};
          exp_toggles++;
        end
        m_ext = 0;
        m_rel = 0;
      end
    endcase
  endtask

  // one bit cell: clock high half (data settles), then low half; optional sub-filter glitches
  task automatic send_bit(input logic d, input bit glitch, input bit last);
    ps2_data = d;
    if (glitch) begin
      repeat (6) @(posedge clk_sys);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk_sys);
      ps2_clk = 1'b1;
      repeat (HALF - 9) @(posedge clk_sys);
    end else begin
      repeat (HALF) @(posedge clk_sys);
    end
    if (last) chk_en = 0;
    ps2_clk = 1'b0;
    if (glitch) begin
      repeat (7) @(posedge clk_sys);
      ps2_clk = 1'b1;
      repeat (3) @(posedge clk_sys);
      ps2_clk = 1'b0;
      repeat (HALF - 10) @(posedge clk_sys);
    end else begin
      repeat (HALF) @(posedge clk_sys);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch, i == 10);
    repeat (HALF) @(posedge clk_sys);
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk_sys);
    model_byte(b, !(bad_par || bad_stop));
    chk_en = 1;
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 0, 0);
    for (int i = 1; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 0, 0);
    repeat (HALF) @(posedge clk_sys);
  endtask

  task automatic do_reset();
    chk_en  = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_perr", 32'(parity_err), 32'h0);
    chk_en = 1;
  endtask

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_t = ps2_key[10];
    end else begin
      if (ps2_key[10] !== prev_t) tog_cnt++;
      prev_t = ps2_key[10];
      if (parity_err) perr_cnt++;
      if (chk_en) begin
        check("key", 32'(ps2_key), 32'(exp_key));
        check("toggles", 32'(tog_cnt), 32'(exp_toggles));
        check("perr", 32'(perr_cnt), 32'(exp_perr));
      end
    end
  end

  initial begin
    int t0, p0;
    logic [7:0] pick [12];
    logic [7:0] b;
    pick = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h1C, 8'h12, 8'h6B, 8'h5A, 8'h29, 8'h00, 8'h1C};

    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset_n  = 1'b0;
    repeat (5) @(posedge clk_sys);
    do_reset();

    // make then break of 0x1C
    t0 = tog_cnt;
    send_frame(8'h1C, 0, 0, 0);
    check("t1_make", 32'(ps2_key), 32'h61C);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check("t1_break", 32'(ps2_key), 32'h01C);
    check("t1_toggles", 32'(tog_cnt - t0), 32'd2);

    // extended make/break
    t0 = tog_cnt;
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h6B, 0, 0, 0);
    check("t2_make", 32'(ps2_key[9:0]), 32'h36B);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h6B, 0, 0, 0);
    check("t2_break", 32'(ps2_key[9:0]), 32'h16B);
    check("t2_toggles", 32'(tog_cnt - t0), 32'd2);

    // parity error leaves the bus untouched
    p0 = perr_cnt;
    send_frame(8'h29, 1, 0, 0);
    check("t3_hold", 32'(ps2_key), 32'h16B);
    check("t3_perr", 32'(perr_cnt - p0), 32'd1);
    send_frame(8'h29, 0, 0, 0);
    check("t3_good", 32'(ps2_key[9:0]), 32'h229);

    // stalled partial frame times out silently
    t0 = tog_cnt;
    p0 = perr_cnt;
    send_partial(3);
    repeat (TIMEOUT + 10) @(posedge clk_sys);
    send_frame(8'h5A, 0, 0, 0);
    check("t4_key", 32'(ps2_key[9:0]), 32'h25A);
    check("t4_toggles", 32'(tog_cnt - t0), 32'd1);
    check("t4_perr", 32'(perr_cnt - p0), 32'd0);

    // Pause sequence produces nothing
    t0 = tog_cnt;
    send_frame(8'hE1, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0);
    send_frame(8'hE1, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0);
    check("t5_pause", 32'(tog_cnt - t0), 32'd0);
    send_frame(8'h12, 0, 0, 0);
    check("t5_key", 32'(ps2_key[9:0]), 32'h212);
    check("t5_toggles", 32'(tog_cnt - t0), 32'd1);

    // typematic repeats with clock glitches
    t0 = tog_cnt;
    send_frame(8'h1C, 0, 0, 1);
    send_frame(8'h1C, 0, 0, 1);
    send_frame(8'h1C, 0, 0, 1);
    send_frame(8'hF0, 0, 0, 1);
    send_frame(8'h1C, 0, 0, 1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("t6_toggles", 32'(tog_cnt - t0), 32'd2);
`else
    check("t6_toggles", 32'(tog_cnt - t0), 32'd4);
`endif
    check("t6_key", 32'(ps2_key[9:0]), 32'h01C);

    // reset in the middle of a frame
    send_frame(8'hE0, 0, 0, 0);
    send_partial(5);
    do_reset();
    send_frame(8'h12, 0, 0, 0);
    check("rst_after", 32'(ps2_key), 32'h612);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 255));
      else b = pick[$urandom_range(0, 11)];
      if ($urandom_range(0, 19) == 0) begin
        send_partial($urandom_range(1, 9));
        repeat (TIMEOUT + 10) @(posedge clk_sys);
      end
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    repeat (5) @(posedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
